// File: rtl/spidac_slave_mcp4921.sv
`default_nettype none
// ============================================================================
//  Module     : spidac_slave_mcp4921
//  Description: MCP4921-style SPI DAC responder. Receives 16-bit write frames
//               on SCK/nCS/SDI, applies nLDAC latch semantics and exposes the
//               decoded DAC state on ports and through an 8-bit register window.
//               Optional macro SPIDAC_SLAVE_STATS_EN adds an accepted-frame
//               counter (offset 3) and a saturating error counter (STATUS[6:4]).
//  Revision   : 1.0 - initial release
// ============================================================================
module spidac_slave_mcp4921 #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 8'h30,
  parameter int                    FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  nRES,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  SCK,
  input  logic                  nCS,
  input  logic                  SDI,
  input  logic                  nLDAC,
  output logic [11:0]           dac_value,
  output logic                  buf_en,
  output logic                  gain_1x,
  output logic                  active,
  output logic                  update,
  output logic                  frame_err
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [DATA_WIDTH-1:0] OFF_STATUS = DATA_WIDTH'(0);
  localparam logic [DATA_WIDTH-1:0] OFF_DAC_LO = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] OFF_DAC_HI = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] OFF_RSVD   = DATA_WIDTH'(3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t          state;
  logic [15:0]     shreg;
  logic [4:0]      bit_cnt;
  logic [14:0]     in_reg;
  logic            pending;
  logic [2:0]      sck_p, ncs_p, sdi_p, nldac_p;   // [0],[1] synchronizer, [2] history
  logic [DATA_WIDTH-1:0] off;
  logic [DATA_WIDTH-1:0] rd_data;

  // Register-window decode; writes act on the next clk edge
  assign off = addr - BASE_ADDR;
  logic wr_status, soft_rst, clr_err;
  assign wr_status = we && (off == OFF_STATUS);
  assign soft_rst  = wr_status && data_in[7];
  assign clr_err   = wr_status && data_in[0];

  logic unused_din;
  assign unused_din = ^data_in[6:1];

  // Edge detection on synchronized pins
  logic sck_rise, ncs_fall, ncs_rise, nldac_fall, nldac_low, sdi_bit;
  assign sck_rise   =  sck_p[1] & ~sck_p[2];
  assign ncs_fall   = ~ncs_p[1] &  ncs_p[2];
  assign ncs_rise   =  ncs_p[1] & ~ncs_p[2];
  assign nldac_fall = ~nldac_p[1] & nldac_p[2];
  assign nldac_low  = ~nldac_p[1];
  assign sdi_bit    =  sdi_p[1];

  // Frame qualification in the CHECK state
  logic check_now, count_ok, accept, err_now;
  assign check_now = (state == ST_CHECK);
  assign count_ok  = (bit_cnt == FRAME_CNT);
  assign accept    = check_now && count_ok && !shreg[15];
  assign err_now   = check_now && !count_ok;

  // Two-flop synchronizers plus history flop for each asynchronous pin
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      sck_p   <= '0;
      ncs_p   <= '0;
      sdi_p   <= '0;
      nldac_p <= '0;
    end else if (soft_rst) begin
      sck_p   <= '0;
      ncs_p   <= '0;
      sdi_p   <= '0;
      nldac_p <= '0;
    end else begin
      sck_p   <= {sck_p[1:0],   SCK};
      ncs_p   <= {ncs_p[1:0],   nCS};
      sdi_p   <= {sdi_p[1:0],   SDI};
      nldac_p <= {nldac_p[1:0], nLDAC};
    end
  end

  // Frame FSM, input register, pending flag and DAC output latch
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      in_reg    <= '0;
      pending   <= 1'b0;
      dac_value <= '0;
      buf_en    <= 1'b0;
      gain_1x   <= 1'b0;
      active    <= 1'b0;
      update    <= 1'b0;
      frame_err <= 1'b0;
    end else if (soft_rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      in_reg    <= '0;
      pending   <= 1'b0;
      dac_value <= '0;
      buf_en    <= 1'b0;
      gain_1x   <= 1'b0;
      active    <= 1'b0;
      update    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ncs_fall) begin
            state   <= ST_SHIFT;
            shreg   <= '0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            shreg <= {shreg[14:0], sdi_bit};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end
          if (ncs_rise) state <= ST_CHECK;
        end
        ST_CHECK: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      // A frame error set in CHECK wins over a simultaneous clear request
      if (err_now)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;

      if (accept) in_reg <= shreg[14:0];

      // Transparent latch of a new frame takes priority over an older pending one
      if (accept && nldac_low) begin
        dac_value <= shreg[11:0];
        active    <= shreg[12];
        gain_1x   <= shreg[13];
        buf_en    <= shreg[14];
        update    <= 1'b1;
        pending   <= 1'b0;
      end else if (accept) begin
        pending   <= 1'b1;
      end else if (nldac_fall && pending) begin
        dac_value <= in_reg[11:0];
        active    <= in_reg[12];
        gain_1x   <= in_reg[13];
        buf_en    <= in_reg[14];
        update    <= 1'b1;
        pending   <= 1'b0;
      end
    end
  end

`ifdef SPIDAC_SLAVE_STATS_EN
  logic [7:0] frame_cnt;
  logic [2:0] err_cnt;
  logic       wr_rsvd;
  assign wr_rsvd = we && (off == OFF_RSVD);

  // Accepted-frame (wrapping) and frame-error (saturating) counters
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (soft_rst || wr_rsvd) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (accept) frame_cnt <= frame_cnt + 8'd1;
      if (err_now && err_cnt != 3'd7) err_cnt <= err_cnt + 3'd1;
    end
  end
`endif

  // Read multiplexer; unmapped offsets return zero
  always_comb begin
    rd_data = '0;
    case (off)
      OFF_STATUS: begin
        rd_data[0] = frame_err;
        rd_data[1] = pending;
        rd_data[2] = (state != ST_IDLE);
`ifdef SPIDAC_SLAVE_STATS_EN
        rd_data[6:4] = err_cnt;
`endif
      end
      OFF_DAC_LO: rd_data[7:0] = dac_value[7:0];
      OFF_DAC_HI: rd_data[7:0] = {active, gain_1x, buf_en, 1'b0, dac_value[11:8]};
      OFF_RSVD: begin
`ifdef SPIDAC_SLAVE_STATS_EN
        rd_data[7:0] = frame_cnt;
`else
        rd_data = '0;
`endif
      end
      default: rd_data = '0;
    endcase
  end

  // Registered read data, one clk after the address
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES)         data_out <= '0;
    else if (soft_rst) data_out <= '0;
    else               data_out <= rd_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_spidac_slave_mcp4921.sv
`default_nettype none
// ============================================================================
//  Module     : tb_spidac_slave_mcp4921
//  Description: Self-checking bench for spidac_slave_mcp4921 with directed and
//               randomized SPI frames against a frame-level reference model.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_spidac_slave_mcp4921;

  localparam logic [7:0] BASE = 8'h30;

  logic        clk = 1'b0;
  logic        nRES = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        SCK = 1'b0, nCS = 1'b1, SDI = 1'b0, nLDAC = 1'b1;
  logic [11:0] dac_value;
  logic        buf_en, gain_1x, active, update, frame_err;

  spidac_slave_mcp4921 dut (
    .clk(clk), .nRES(nRES), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .SCK(SCK), .nCS(nCS), .SDI(SDI), .nLDAC(nLDAC),
    .dac_value(dac_value), .buf_en(buf_en), .gain_1x(gain_1x),
    .active(active), .update(update), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;

  // Count every clk cycle in which update is high
  always @(posedge clk) if (update === 1'b1) upd_cnt <= upd_cnt + 1;

  // Reference model state (frame-level)
  logic [11:0] m_dac;
  logic        m_buf, m_gain, m_act, m_pend, m_err;
  logic [14:0] m_in;
  int          m_errcnt, m_frames, m_upd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_dac = '0; m_buf = 0; m_gain = 0; m_act = 0; m_pend = 0; m_err = 0;
    m_in = '0; m_errcnt = 0; m_frames = 0;
  endtask

  task automatic m_latch();
    m_dac  = m_in[11:0];
    m_act  = m_in[12];
    m_gain = m_in[13];
    m_buf  = m_in[14];
    m_pend = 0;
    m_upd++;
  endtask

  task automatic rd(input logic [7:0] off, output logic [7:0] v);
    @(negedge clk);
    addr = BASE + off;
    @(posedge clk);
    #1 v = data_out;
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    @(negedge clk);
    we = 1; addr = BASE + off; data_in = d;
    @(negedge clk);
    we = 0; data_in = '0;
    if (off == 8'd0) begin
      if (d[7]) model_reset();
      else if (d[0]) m_err = 0;
    end
    if (off == 8'd3) begin m_errcnt = 0; m_frames = 0; end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    nRES = 0;
    tick(2);
    nRES = 1;
    model_reset();
    tick(3);
  endtask

  // mode 0: nLDAC idle high, 1: nLDAC held low around the frame, 2: nLDAC pulse after
  task automatic spi(input logic [31:0] v, input int n, input int mode, output int lat);
    int u0;
    lat = -1;
    if (mode == 1) begin
      @(negedge clk); nLDAC = 0;
      if (m_pend) m_latch();
      tick(5);
    end
    @(negedge clk); nCS = 0;
    tick(3);
    for (int i = n - 1; i >= 0; i--) begin
      SDI = v[i]; tick(2); SCK = 1; tick(2); SCK = 0;
    end
    tick(2);
    u0 = upd_cnt;
    nCS = 1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (upd_cnt != u0 && lat < 0) lat = k;
    end
    if (n != 16) begin
      m_err = 1;
      if (m_errcnt < 7) m_errcnt++;
    end else if (!v[15]) begin
      m_in = v[14:0];
      m_frames++;
      if (mode == 1) m_latch();
      else m_pend = 1;
    end
    if (mode == 1) begin nLDAC = 1; tick(4); end
    if (mode == 2) begin
      nLDAC = 0; tick(4); nLDAC = 1; tick(4);
      if (m_pend) m_latch();
    end
    tick(2);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] v, es, e3;
    es = {1'b0, 3'b000, 1'b0, 1'b0, m_pend, m_err};
    e3 = 8'h00;
`ifdef SPIDAC_SLAVE_STATS_EN
    es[6:4] = 3'(m_errcnt);
    e3 = 8'(m_frames % 256);
`endif
    chk({tag, "/dac"},    32'(dac_value), 32'(m_dac));
    chk({tag, "/buf"},    32'(buf_en),    32'(m_buf));
    chk({tag, "/gain"},   32'(gain_1x),   32'(m_gain));
    chk({tag, "/active"}, 32'(active),    32'(m_act));
    chk({tag, "/ferr"},   32'(frame_err), 32'(m_err));
    chk({tag, "/updcnt"}, 32'(upd_cnt),   32'(m_upd));
    rd(8'd0, v); chk({tag, "/status"}, 32'(v), 32'(es));
    rd(8'd1, v); chk({tag, "/daclo"},  32'(v), 32'(m_dac[7:0]));
    rd(8'd2, v); chk({tag, "/dachi"},  32'(v), 32'({m_act, m_gain, m_buf, 1'b0, m_dac[11:8]}));
    rd(8'd3, v); chk({tag, "/off3"},   32'(v), 32'(e3));
  endtask

  initial begin
    int lat, u0, n, mode;
    logic [31:0] v;
    logic [7:0] r;
    m_upd = 0;
    model_reset();
    tick(3);
    chk("rst_dout", 32'(data_out), 32'h0);
    chk("rst_dac",  32'(dac_value), 32'h0);
    nRES = 1;
    tick(3);
    check_all("reset");
    rd(8'h10, r); chk("unmapped", 32'(r), 32'h0);

    // Frame 0x3ABC latched by an nLDAC pulse
    u0 = upd_cnt;
    spi(32'h3ABC, 16, 2, lat);
    check_all("f3ABC");
    chk("3ABC_dac", 32'(dac_value), 32'hABC);
    chk("3ABC_bits", 32'({buf_en, gain_1x, active}), 32'b011);
    chk("3ABC_one_upd", 32'(upd_cnt - u0), 32'd1);
    rd(8'd2, r); chk("3ABC_hi", 32'(r), 32'hCA);
    rd(8'd1, r); chk("3ABC_lo", 32'(r), 32'hBC);

    // Transparent mode: nLDAC held low
    spi(32'h7123, 16, 1, lat);
    chk("7123_latency", 32'(lat >= 1 && lat <= 5), 32'd1);
    chk("7123_dac", 32'(dac_value), 32'h123);
    chk("7123_buf", 32'(buf_en), 32'd1);
    check_all("f7123");

    // bit15 set: silently ignored
    spi(32'hF555, 16, 0, lat);
    check_all("fF555");
    chk("F555_noerr", 32'(frame_err), 32'd0);

    // Short and long frames
    spi(32'h1234, 15, 0, lat);
    check_all("f15");
    spi(32'h12345, 17, 0, lat);
    check_all("f17");
`ifdef SPIDAC_SLAVE_STATS_EN
    rd(8'd0, r); chk("errcnt2", 32'(r[6:4]), 32'd2);
`endif
    wr(8'd0, 8'h01);
    check_all("clr_err");

    // Pending frame discarded by nRES
    pulse_reset();
    spi(32'h3FFF, 16, 0, lat);
    check_all("f3FFF_pend");
    chk("3FFF_dac0", 32'(dac_value), 32'h0);
    pulse_reset();
    check_all("after_nres");
    u0 = upd_cnt;
    @(negedge clk); nLDAC = 0; tick(4); nLDAC = 1; tick(4);
    chk("nldac_no_pend", 32'(upd_cnt - u0), 32'd0);
    check_all("nldac_idle");

    // Soft reset through STATUS bit7
    spi(32'h1234, 16, 2, lat);
    check_all("f1234");
    wr(8'd0, 8'h80);
    tick(2);
    check_all("soft_rst");

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      v = $urandom;
      case ($urandom_range(0, 9))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      if (n == 16) v[15] = ($urandom_range(0, 3) == 0);
      mode = $urandom_range(0, 2);
      spi(v, n, mode, lat);
      if ($urandom_range(0, 5) == 0) wr(8'd0, 8'h01);
      check_all($sformatf("rnd%0d", t));
    end

`ifdef SPIDAC_SLAVE_STATS_EN
    wr(8'd3, 8'h00);
    for (int t = 0; t < 300; t++) begin
      v = $urandom;
      v[15] = 1'b0;
      spi(v, 16, 0, lat);
    end
    rd(8'd3, r); chk("stats300", 32'(r), 32'd44);
    wr(8'd3, 8'h00);
    rd(8'd3, r); chk("stats_clr", 32'(r), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spidac_slave_mcp4921.md
Name: spidac_slave_mcp4921

Overview:
- Responder-side model of the MCP4921 SPI DAC link. Receives 16-bit write frames on SCK/nCS/SDI and applies nLDAC latch semantics.
- Exposes the decoded DAC state on ports and through the same 8-bit register window style (we/addr/data_in/data_out) used by the SPI DAC master wrapper.
- Used as an on-FPGA loopback monitor for the DAC master path and as a bench target for that master.

Parameters:
- DATA_WIDTH, 8, register bus width.
- BASE_ADDR, 8'h30, address of register 0; registers occupy BASE_ADDR..BASE_ADDR+3.
- FRAME_BITS, 16, required SCK rising edges per valid frame.

Ports:
- clk  in  1  system clock; must be >= 4x SCK frequency.
- nRES  in  1  reset, asynchronous, active-low.
- we  in  1  register write strobe.
- addr  in  DATA_WIDTH  register address.
- data_in  in  DATA_WIDTH  register write data.
- data_out  out  DATA_WIDTH  registered read data.
- SCK  in  1  SPI clock from master (async).
- nCS  in  1  SPI chip select, active-low (async).
- SDI  in  1  SPI data, MSB first (async).
- nLDAC  in  1  latch DAC, active-low (async).
- dac_value  out  12  active DAC code.
- buf_en  out  1  active BUF bit.
- gain_1x  out  1  active nGA bit (1 = 1x, 0 = 2x).
- active  out  1  active nSHDN bit (0 = output shut down).
- update  out  1  one-cycle pulse when the DAC register changes.
- frame_err  out  1  sticky error flag.

Behaviour:
- Reset (nRES low, async): all outputs 0, data_out 0. Input and DAC registers 0, shift count 0, FSM IDLE.
- Sync: SCK, nCS, SDI and nLDAC each pass through a 2-FF synchronizer plus a history FF. Edges are detected on synced values, giving 3-4 clk latency from pin to action.
- FSM IDLE:
  - synced nCS falling -> SHIFT; clear shift register and bit count.
- FSM SHIFT:
  - On each synced SCK rising edge: shift in SDI (MSB first); bit count saturates at 31.
  - Synced nCS rising -> CHECK.
- FSM CHECK (1 cycle), then -> IDLE:
  - count != FRAME_BITS: set frame_err; input register unchanged.
  - count == FRAME_BITS and bit15 == 1: frame ignored, no error (MCP4921 rule).
  - Otherwise: input register <= {BUF=bit14, nGA=bit13, nSHDN=bit12, D=bit11:0}; set pending.
- Latch to DAC register (copies the input register to the outputs, pulses update next cycle, clears pending):
  - (a) synced nLDAC falling edge while pending, or
  - (b) CHECK accepts a frame while synced nLDAC is low (transparent mode).
  - nLDAC falling with no pending frame: no action.
- Simultaneous events: CHECK accept and nLDAC falling in the same cycle produce a single latch of the new frame.
- nCS rising while in IDLE: ignored.
- nRES asserted mid-frame: frame discarded, everything returns to reset values.
- Registers (offset from BASE_ADDR):
  - 0 STATUS: bit0 frame_err, bit1 pending, bit2 FSM busy (SHIFT/CHECK), others 0. Writing with bit0=1 clears frame_err; bit7=1 performs a soft reset equivalent to nRES.
  - 1 DAC_LO: dac_value[7:0], read-only.
  - 2 DAC_HI: {active, gain_1x, buf_en, 1'b0, dac_value[11:8]}, read-only.
  - 3 reserved: reads 0.
- Register writes take effect the next clk. data_out updates one clk after addr; unmapped addresses return 0.

Optional Feature:
- Macro SPIDAC_SLAVE_STATS_EN.
- Defined: offset 3 reads an 8-bit wrapping count of accepted frames, and offset 3 bits[7:4] of STATUS... instead, STATUS bits[6:4] hold a 3-bit saturating error count. Both counters clear on reset, on soft reset, or on any write to offset 3.
- Undefined: offset 3 reads 0, STATUS[6:4] read 0, and no counter logic is generated.

Test Plan:
- Frame 16'h3ABC, then nLDAC pulse low -> dac_value=12'hABC, buf_en=0, gain_1x=1, active=1; exactly one update pulse; DAC_HI reads 8'hCA, DAC_LO reads 8'hBC.
- Frame 16'h7123 with nLDAC held low -> latch without an nLDAC edge, within 5 clk of nCS rising; dac_value=12'h123, buf_en=1.
- Frame 16'hF555 -> ignored, outputs unchanged, frame_err=0, pending=0.
- 15-bit frame, then 17-bit frame -> frame_err=1 and outputs unchanged both times; STATUS write 8'h01 -> frame_err=0. With stats enabled, STATUS[6:4]=2.
- Frame 16'h3FFF without nLDAC -> pending=1, outputs still 0; then nRES pulse -> pending=0, and a later nLDAC falling edge gives no update.
- Stats enabled: 300 valid frames -> offset 3 reads 8'd44 (300 mod 256); write offset 3 -> reads 0.
